// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready handshake
// and presents the buffered instruction plus PC+4 to the IF/ID register.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_Write,
    input  logic        IF_Flush,
    input  logic [31:0] Branch_Target,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic [31:0] IMem_Rdata,
    input  logic        IMem_Ready,
    output logic [31:0] PC_out,
    output logic [31:0] PC_4_out,
    output logic [31:0] Instruction_out,
    output logic        Fetch_Valid
);

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HAVE
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ibuf, ibuf_n;
    logic [31:0] pc4buf, pc4buf_n;
    logic [31:0] redirect, redirect_n;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = {Branch_Target[31:2], 2'b00};
    assign pc_inc = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            ibuf     <= NOP_INSTR;
            pc4buf   <= '0;
            redirect <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ibuf     <= ibuf_n;
            pc4buf   <= pc4buf_n;
            redirect <= redirect_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ibuf_n     = ibuf;
        pc4buf_n   = pc4buf;
        redirect_n = redirect;
        case (state)
            FETCH: begin
                if (IMem_Ready) begin
                    if (IF_Flush) begin
                        pc_n = target;
                    end else begin
                        ibuf_n   = IMem_Rdata;
                        pc4buf_n = pc_inc;
                        state_n  = HAVE;
                    end
                end else if (IF_Flush) begin
                    // Address must stay put while the request is outstanding;
                    // park the target until memory completes the stale fetch.
                    redirect_n = target;
                    state_n    = DRAIN;
                end
            end
            DRAIN: begin
                if (IF_Flush) begin
                    redirect_n = target;
                end
                if (IMem_Ready) begin
                    pc_n    = IF_Flush ? target : redirect;
                    state_n = FETCH;
                end
            end
            HAVE: begin
                if (IF_Flush) begin
                    pc_n    = target;
                    ibuf_n  = NOP_INSTR;
                    state_n = FETCH;
                end else if (PC_Write) begin
                    pc_n    = pc_inc;
                    state_n = FETCH;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    assign IMem_Req        = !rst && (state == FETCH || state == DRAIN);
    assign IMem_Addr       = pc;
    assign PC_out          = pc;
    assign PC_4_out        = pc4buf;
    assign Fetch_Valid     = (state == HAVE);
    assign Instruction_out = (state == HAVE) ? ibuf : NOP_INSTR;

endmodule
